// File: rtl/s7_pkg.sv
// Shared definitions for the s7 seven-segment display blocks.
package s7_pkg;

  localparam int DIGIT_W    = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // Widest BCD word the validity helper accepts (16 digits); narrower words are zero-padded.
  localparam int WORD_MAX_W = 64;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t SHOW    = 2'd1;
  localparam arb_state_t RELEASE = 2'd2;

  function automatic logic bcd_word_invalid(input logic [WORD_MAX_W-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < WORD_MAX_W / DIGIT_W; i++) begin
      if (word[i*DIGIT_W +: DIGIT_W] > BCD_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/s7_rr_pick.sv
// Combinational round-robin picker: first active request at or after i_ptr, wrapping modulo N.
module s7_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [2*N-1:0] rot_req;
  logic [IDX_W:0] sum;

  always_comb begin
    rot_req = {i_req, i_req} >> i_ptr;
    sum     = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!o_valid && rot_req[i]) begin
        o_valid = 1'b1;
        sum     = {1'b0, i_ptr} + (IDX_W+1)'(i);
        if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
        o_idx   = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/s7_disp_arbiter.sv
// Round-robin owner of a shared s7_display: one requester holds the BCD word for a fixed window.
//
// state   | meaning
// IDLE    | nobody owns the display; arbitrate on any active request
// SHOW    | owner's word is shown live; counts down the hold window
// RELEASE | one-cycle gap: grant cleared, done pulsed, pointer advanced
module s7_disp_arbiter
  import s7_pkg::*;
#(
  parameter int DIS_NUM  = 4,
  parameter int REQ_NUM  = 3,
  parameter int HOLD_CNT = 1000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [REQ_NUM-1:0]           i_req,
  input  logic [REQ_NUM*DIS_NUM*4-1:0] i_bcd_data,
  output logic [REQ_NUM-1:0]           o_grant,
  output logic [REQ_NUM-1:0]           o_done,
  output logic [DIS_NUM*4-1:0]         o_bcd_data,
  output logic                         o_bcd_err,
  output logic                         o_busy
);

  localparam int WORD_W = DIS_NUM * DIGIT_W;
  localparam int IDX_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W  = $clog2(HOLD_CNT);

  arb_state_t         state_q, state_d;
  logic [REQ_NUM-1:0] grant_q, grant_d;
  logic [REQ_NUM-1:0] done_q, done_d;
  logic [WORD_W-1:0]  bcd_q, bcd_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [WORD_W-1:0]  owner_word;
  logic [WORD_W-1:0]  win_word;
  logic [REQ_NUM-1:0] win_onehot;
  logic               owner_req;

  s7_rr_pick #(
    .N     (REQ_NUM),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (i_req),
    .i_ptr   (rr_ptr_q),
    .o_valid (pick_valid),
    .o_idx   (pick_idx)
  );

  always_comb begin
    owner_word = '0;
    win_word   = '0;
    win_onehot = '0;
    owner_req  = 1'b0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (owner_q == IDX_W'(k)) begin
        owner_word = i_bcd_data[k*WORD_W +: WORD_W];
        owner_req  = i_req[k];
      end
      if (pick_idx == IDX_W'(k)) begin
        win_word      = i_bcd_data[k*WORD_W +: WORD_W];
        win_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    bcd_d    = bcd_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = SHOW;
          owner_d = pick_idx;
          grant_d = win_onehot;
          bcd_d   = win_word;
          cnt_d   = CNT_W'(HOLD_CNT - 1);
        end
      end
      SHOW: begin
        bcd_d = owner_word;
        // Terminal count and early release share one exit, so done pulses once.
        if (cnt_q == '0 || !owner_req) begin
          state_d  = RELEASE;
          grant_d  = '0;
          done_d   = grant_q;
          rr_ptr_d = (owner_q == IDX_W'(REQ_NUM - 1)) ? '0 : owner_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Flag derived from the word being loaded so the two registers stay aligned.
  assign err_d = bcd_word_invalid(WORD_MAX_W'(bcd_d));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      bcd_q    <= '0;
      err_q    <= 1'b0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_done     = done_q;
  assign o_bcd_data = bcd_q;
  assign o_bcd_err  = err_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_s7_disp_arbiter.sv
// Scoreboard bench for s7_disp_arbiter with DIS_NUM=4, REQ_NUM=3, HOLD_CNT=4.
module tb_s7_disp_arbiter;

  localparam int K_GRANT = 0;
  localparam int K_DATA  = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int          kind;
    logic [2:0]  vec;
    logic [15:0] data;
    logic        err;
    int          t;
    int          gl;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [47:0] bcd = '0;
  logic [2:0]  o_grant;
  logic [2:0]  o_done;
  logic [15:0] o_bcd_data;
  logic        o_bcd_err;
  logic        o_busy;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  ev_idx = 0;
  ev_t exp_q[$];

  s7_disp_arbiter #(
    .DIS_NUM  (4),
    .REQ_NUM  (3),
    .HOLD_CNT (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_bcd_data (bcd),
    .o_grant    (o_grant),
    .o_done     (o_done),
    .o_bcd_data (o_bcd_data),
    .o_bcd_err  (o_bcd_err),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #20000;
    $display("FAIL timeout: bench did not reach its summary, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [15:0] w);
    case (k)
      0:       bcd[15:0]  = w;
      1:       bcd[31:16] = w;
      default: bcd[47:32] = w;
    endcase
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_ev(input int kind, input logic [2:0] vec, input logic [15:0] d,
                        input logic e, input int t, input int gl);
    ev_t x;
    x.kind = kind; x.vec = vec; x.data = d; x.err = e; x.t = t; x.gl = gl;
    exp_q.push_back(x);
  endtask

  task automatic take(input int kind, input logic [2:0] vec, input logic [15:0] d,
                      input logic e, input int gl);
    ev_t x;
    logic bad;
    n_tests++;
    ev_idx++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event #%0d: kind=%0d vec=%b data=%h at cycle %0d, none expected",
               ev_idx, kind, vec, d, cyc);
      return;
    end
    x = exp_q.pop_front();
    bad = (x.kind != kind) || (x.vec !== vec);
    if (kind != K_DONE && ((x.data !== d) || (x.err !== e))) bad = 1'b1;
    if (x.t >= 0 && x.t != cyc) bad = 1'b1;
    if (x.gl >= 0 && x.gl != gl) bad = 1'b1;
    if (bad) begin
      n_fail++;
      $display("FAIL event #%0d: got kind=%0d vec=%b data=%h err=%b cyc=%0d gap/len=%0d, expected kind=%0d vec=%b data=%h err=%b cyc=%0d gap/len=%0d",
               ev_idx, kind, vec, d, e, cyc, gl, x.kind, x.vec, x.data, x.err, x.t, x.gl);
    end
  endtask

  // Monitor: turns DUT activity into events and checks them against the queue.
  initial begin
    logic [2:0]  prev_g;
    logic [15:0] prev_d;
    int          run_len;
    int          zero_len;
    prev_g = '0; prev_d = '0; run_len = 0; zero_len = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        n_tests++;
        if (!$onehot0(o_grant) || !$onehot0(o_done) || (o_done & o_grant) != 3'b000 ||
            (o_grant != 3'b000 && prev_g != 3'b000 && o_grant != prev_g)) begin
          n_fail++;
          $display("FAIL invariants: grant=%b done=%b prev_grant=%b at cycle %0d",
                   o_grant, o_done, prev_g, cyc);
        end
        if (o_grant != 3'b000 && prev_g == 3'b000) begin
          take(K_GRANT, o_grant, o_bcd_data, o_bcd_err, zero_len);
          run_len = 1;
        end else if (o_grant != 3'b000) begin
          run_len++;
          if (o_bcd_data !== prev_d) take(K_DATA, o_grant, o_bcd_data, o_bcd_err, -1);
        end
        if (o_grant == 3'b000) zero_len = (prev_g == 3'b000) ? zero_len + 1 : 1;
        if (o_done != 3'b000) take(K_DONE, o_done, 16'h0, 1'b0, run_len);
      end
      prev_g = o_grant;
      prev_d = o_bcd_data;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    step(2);
    chk("reset_grant", 16'(o_grant), 16'h0);
    chk("reset_done", 16'(o_done), 16'h0);
    chk("reset_data", o_bcd_data, 16'h0);
    chk("reset_err", 16'(o_bcd_err), 16'h0);
    chk("reset_busy", 16'(o_busy), 16'h0);
    rst = 1'b0;
    step(2);

    // 1: single requester, full slot, re-grant after the gap
    set_word(1, 16'h1234);
    req = 3'b010;
    n = cyc;
    exp_ev(K_GRANT, 3'b010, 16'h1234, 1'b0, n + 1, -1);
    exp_ev(K_DONE,  3'b010, 16'h0,    1'b0, n + 5, 4);
    exp_ev(K_GRANT, 3'b010, 16'h1234, 1'b0, n + 7, 2);
    exp_ev(K_DONE,  3'b010, 16'h0,    1'b0, n + 11, 4);
    step(11);
    req = 3'b000;
    step(3);

    // 2: fairness with all three requesting
    do_reset();
    set_word(0, 16'h1111); set_word(1, 16'h2222); set_word(2, 16'h3333);
    req = 3'b111;
    n = cyc;
    exp_ev(K_GRANT, 3'b001, 16'h1111, 1'b0, n + 1, -1);
    exp_ev(K_DONE,  3'b001, 16'h0,    1'b0, -1, 4);
    exp_ev(K_GRANT, 3'b010, 16'h2222, 1'b0, n + 7, 2);
    exp_ev(K_DONE,  3'b010, 16'h0,    1'b0, -1, 4);
    exp_ev(K_GRANT, 3'b100, 16'h3333, 1'b0, n + 13, 2);
    exp_ev(K_DONE,  3'b100, 16'h0,    1'b0, -1, 4);
    exp_ev(K_GRANT, 3'b001, 16'h1111, 1'b0, n + 19, 2);
    exp_ev(K_DONE,  3'b001, 16'h0,    1'b0, n + 23, 4);
    step(23);
    req = 3'b000;
    step(3);

    // 3: early release by requester 0, requester 1 takes over
    do_reset();
    set_word(0, 16'h0555); set_word(1, 16'h0666);
    req = 3'b011;
    n = cyc;
    exp_ev(K_GRANT, 3'b001, 16'h0555, 1'b0, n + 1, -1);
    exp_ev(K_DONE,  3'b001, 16'h0,    1'b0, n + 3, 2);
    exp_ev(K_GRANT, 3'b010, 16'h0666, 1'b0, n + 5, 2);
    exp_ev(K_DONE,  3'b010, 16'h0,    1'b0, n + 9, 4);
    step(2);
    req = 3'b010;
    step(7);
    req = 3'b000;
    step(3);

    // 4: invalid digit appears and disappears mid-slot
    do_reset();
    set_word(0, 16'h0009);
    req = 3'b001;
    n = cyc;
    exp_ev(K_GRANT, 3'b001, 16'h0009, 1'b0, n + 1, -1);
    step(1);
    set_word(0, 16'h00A9);
    exp_ev(K_DATA, 3'b001, 16'h00A9, 1'b1, cyc + 1, -1);
    step(1);
    set_word(0, 16'h0009);
    exp_ev(K_DATA, 3'b001, 16'h0009, 1'b0, cyc + 1, -1);
    exp_ev(K_DONE, 3'b001, 16'h0, 1'b0, n + 5, 4);
    step(3);
    req = 3'b000;
    step(3);
    chk("idle_hold_data", o_bcd_data, 16'h0009);
    chk("idle_busy", 16'(o_busy), 16'h0);

    // 5: asynchronous reset in the middle of a slot
    req = 3'b001;
    n = cyc;
    exp_ev(K_GRANT, 3'b001, 16'h0009, 1'b0, n + 1, -1);
    step(2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_grant", 16'(o_grant), 16'h0);
    chk("midrst_data", o_bcd_data, 16'h0);
    chk("midrst_busy", 16'(o_busy), 16'h0);
    chk("midrst_done", 16'(o_done), 16'h0);
    chk("midrst_err", 16'(o_bcd_err), 16'h0);
    req = 3'b100;
    set_word(2, 16'h0789);
    step(1);
    rst = 1'b0;
    n = cyc;
    exp_ev(K_GRANT, 3'b100, 16'h0789, 1'b0, n + 1, -1);
    exp_ev(K_DONE,  3'b100, 16'h0,    1'b0, n + 5, 4);
    step(5);
    req = 3'b000;
    step(3);

    // 6: request drop on the terminal-count cycle, then re-request during RELEASE
    set_word(0, 16'h0042); set_word(1, 16'h0077);
    req = 3'b001;
    n = cyc;
    exp_ev(K_GRANT, 3'b001, 16'h0042, 1'b0, n + 1, -1);
    exp_ev(K_DONE,  3'b001, 16'h0,    1'b0, n + 5, 4);
    exp_ev(K_GRANT, 3'b010, 16'h0077, 1'b0, n + 7, 2);
    exp_ev(K_DONE,  3'b010, 16'h0,    1'b0, n + 11, 4);
    step(4);
    req = 3'b000;
    step(1);
    req = 3'b111;
    step(6);
    req = 3'b000;
    step(4);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    chk("pending_events", 16'(exp_q.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
